// File: rtl/avs_uart_fifo_pkg.sv
// uart_pkg: shared constants, FSM state type and parity helper for avs_uart_fifo.
// Optional feature macro used by the UART: UART_PARITY_EN (even parity bit).
package uart_pkg;

    // Avalon-MM word addresses
    localparam logic [1:0] ADDR_RXDATA = 2'd0;
    localparam logic [1:0] ADDR_TXDATA = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    // STATUS sticky bit positions
    localparam int STAT_TX_OVF = 0;
    localparam int STAT_RX_OVF = 1;
    localparam int STAT_FERR   = 2;
    localparam int STAT_PERR   = 3;

    // Smallest divisor the bit timers can honour (half-bit must be >= 2)
    localparam logic [15:0] DIV_MIN = 16'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Even parity bit: makes the total number of ones (data + parity) even
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/avs_uart_fifo_if.sv
// Avalon-MM slave bus bundle for avs_uart_fifo.
interface avs_uart_fifo_if;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata,
        output avs_waitrequest
    );

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata,
        input  avs_waitrequest
    );
endinterface

// File: rtl/avs_uart_fifo_sync_fifo.sv
// uart_sync_fifo: show-ahead synchronous FIFO. Simultaneous push and pop both
// take effect (even when full); a pop on empty is ignored; a push that finds
// no room is dropped and flagged on o_drop for that cycle.
module uart_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count,
    output logic             o_empty,
    output logic             o_drop
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign w_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == {CW{1'b0}});
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~w_full | w_pop_ok);
    assign o_drop    = i_push & ~w_push_ok;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage array: written on accepted push, no reset needed
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/avs_uart_fifo.sv
// avs_uart_fifo: Avalon-MM UART with RX/TX FIFOs, programmable divisor and
// level interrupt. Define UART_PARITY_EN to add an even parity bit per frame.
module avs_uart_fifo
    import uart_pkg::*;
#(
    parameter int DIV_RESET  = 434,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    avs_uart_fifo_if.slave avs,
    output logic           irq,
    input  logic           uart_rxd,
    output logic           uart_txd
);

`ifdef UART_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    // Control / status registers
    logic [15:0] r_div;
    logic        r_rx_ie;
    logic        r_tx_empty_ie;
    logic        r_tx_ovf;
    logic        r_rx_ovf;
    logic        r_ferr;
    logic        r_perr;
    logic [DATA_BITS-1:0] r_rx_hold;
    logic [15:0] w_div_eff;

    // Bus decode
    logic w_rx_pop;
    logic w_tx_push;
    logic w_stat_wr;
    logic w_ctrl_wr;
    logic w_unused_wdata;

    // FIFO connections
    logic [DATA_BITS-1:0] w_rx_rdata;
    logic [DATA_BITS-1:0] w_tx_rdata;
    logic [CW-1:0]        w_rx_count;
    logic [CW-1:0]        w_tx_count;
    logic                 w_rx_empty;
    logic                 w_tx_empty;
    logic                 w_rx_drop;
    logic                 w_tx_drop;
    logic [7:0]           w_rx_byte;
    logic [7:0]           w_tx_load;

    // Receiver
    logic        r_rxd_meta;
    logic        r_rxd_sync;
    logic        r_rxd_prev;
    uart_state_e r_rx_state, w_rx_state_nxt;
    logic [15:0] r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0]  r_rx_bit, w_rx_bit_nxt;
    logic [7:0]  r_rx_shift, w_rx_shift_nxt;
    logic        r_rx_par, w_rx_par_nxt;
    logic [15:0] r_rx_div, w_rx_div_nxt;
    logic [15:0] w_rx_half;
    logic        w_rx_push;
    logic        w_ferr_set;
    logic        w_perr_set;

    // Transmitter
    uart_state_e r_tx_state, w_tx_state_nxt;
    logic [15:0] r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0]  r_tx_bit, w_tx_bit_nxt;
    logic [7:0]  r_tx_shift, w_tx_shift_nxt;
    logic [15:0] r_tx_div, w_tx_div_nxt;
    logic        r_txd, w_txd_nxt;
    logic        w_tx_pop;

    assign avs.avs_waitrequest = 1'b0;
    assign w_unused_wdata = ^avs.avs_writedata[31:18];

    assign w_rx_pop  = avs.avs_read  & (avs.avs_address == ADDR_RXDATA) & ~w_rx_empty;
    assign w_tx_push = avs.avs_write & (avs.avs_address == ADDR_TXDATA);
    assign w_stat_wr = avs.avs_write & (avs.avs_address == ADDR_STATUS);
    assign w_ctrl_wr = avs.avs_write & (avs.avs_address == ADDR_CTRL);

    assign w_div_eff = (r_div < DIV_MIN) ? DIV_MIN : r_div;
    assign w_rx_half = {1'b0, r_rx_div[15:1]};

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_rx_push),
        .i_wdata (r_rx_shift[DATA_BITS-1:0]),
        .i_pop   (w_rx_pop),
        .o_rdata (w_rx_rdata),
        .o_count (w_rx_count),
        .o_empty (w_rx_empty),
        .o_drop  (w_rx_drop)
    );

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_tx_push),
        .i_wdata (avs.avs_writedata[DATA_BITS-1:0]),
        .i_pop   (w_tx_pop),
        .o_rdata (w_tx_rdata),
        .o_count (w_tx_count),
        .o_empty (w_tx_empty),
        .o_drop  (w_tx_drop)
    );

    // Zero-extend FIFO data; an empty RX FIFO shows the last popped byte
    always_comb begin
        w_rx_byte = 8'd0;
        w_tx_load = 8'd0;
        if (w_rx_empty) begin
            w_rx_byte[DATA_BITS-1:0] = r_rx_hold;
        end else begin
            w_rx_byte[DATA_BITS-1:0] = w_rx_rdata;
        end
        w_tx_load[DATA_BITS-1:0] = w_tx_rdata;
    end

    // Combinational register read mux
    always_comb begin
        avs.avs_readdata = 32'd0;
        case (avs.avs_address)
            ADDR_RXDATA: avs.avs_readdata = {23'd0, ~w_rx_empty, w_rx_byte};
            ADDR_STATUS: avs.avs_readdata = {8'(w_rx_count), 8'(w_tx_count), 12'd0,
                                             r_perr, r_ferr, r_rx_ovf, r_tx_ovf};
            ADDR_CTRL:   avs.avs_readdata = {14'd0, r_tx_empty_ie, r_rx_ie, r_div};
            default:     avs.avs_readdata = 32'd0;
        endcase
    end

    // CTRL register, hold copy of the last popped RX byte
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div         <= 16'(DIV_RESET);
            r_rx_ie       <= 1'b0;
            r_tx_empty_ie <= 1'b0;
            r_rx_hold     <= {DATA_BITS{1'b0}};
        end else begin
            if (w_ctrl_wr) begin
                r_div         <= avs.avs_writedata[15:0];
                r_rx_ie       <= avs.avs_writedata[16];
                r_tx_empty_ie <= avs.avs_writedata[17];
            end
            if (w_rx_pop) begin
                r_rx_hold <= w_rx_rdata;
            end
        end
    end

    // Sticky error flags: a new event wins over a same-cycle write-1-to-clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_ovf <= 1'b0;
            r_rx_ovf <= 1'b0;
            r_ferr   <= 1'b0;
            r_perr   <= 1'b0;
        end else begin
            if (w_tx_drop)                                        r_tx_ovf <= 1'b1;
            else if (w_stat_wr && avs.avs_writedata[STAT_TX_OVF]) r_tx_ovf <= 1'b0;
            if (w_rx_drop)                                        r_rx_ovf <= 1'b1;
            else if (w_stat_wr && avs.avs_writedata[STAT_RX_OVF]) r_rx_ovf <= 1'b0;
            if (w_ferr_set)                                       r_ferr <= 1'b1;
            else if (w_stat_wr && avs.avs_writedata[STAT_FERR])   r_ferr <= 1'b0;
            if (w_perr_set)                                       r_perr <= 1'b1;
            else if (w_stat_wr && avs.avs_writedata[STAT_PERR])   r_perr <= 1'b0;
        end
    end

    // Two-flop synchroniser plus previous-sample register for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_rxd_meta <= uart_rxd;
            r_rxd_sync <= r_rxd_meta;
            r_rxd_prev <= r_rxd_sync;
        end
    end

    // RX state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_state <= ST_IDLE;
            r_rx_cnt   <= 16'd0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'd0;
            r_rx_par   <= 1'b0;
            r_rx_div   <= DIV_MIN;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_par   <= w_rx_par_nxt;
            r_rx_div   <= w_rx_div_nxt;
        end
    end

    // RX next-state: mid-bit sampling, start-glitch rejection, stop/parity checks
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt + 16'd1;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_par_nxt   = r_rx_par;
        w_rx_div_nxt   = r_rx_div;
        w_rx_push      = 1'b0;
        w_ferr_set     = 1'b0;
        w_perr_set     = 1'b0;
        case (r_rx_state)
            ST_IDLE: begin
                w_rx_cnt_nxt = 16'd0;
                if (r_rxd_prev && !r_rxd_sync) begin
                    w_rx_state_nxt = ST_START;
                    w_rx_div_nxt   = w_div_eff;
                end else begin
                    w_rx_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (r_rx_cnt == w_rx_half - 16'd1) begin
                    w_rx_cnt_nxt = 16'd0;
                    if (r_rxd_sync) begin
                        w_rx_state_nxt = ST_IDLE;
                    end else begin
                        w_rx_state_nxt = ST_DATA;
                        w_rx_bit_nxt   = 3'd0;
                        w_rx_shift_nxt = 8'd0;
                    end
                end else begin
                    w_rx_state_nxt = ST_START;
                end
            end
            ST_DATA: begin
                if (r_rx_cnt == r_rx_div - 16'd1) begin
                    w_rx_cnt_nxt = 16'd0;
                    w_rx_shift_nxt[r_rx_bit] = r_rxd_sync;
                    if (r_rx_bit == LAST_BIT) begin
                        w_rx_state_nxt = PARITY_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        w_rx_bit_nxt = r_rx_bit + 3'd1;
                    end
                end else begin
                    w_rx_state_nxt = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (r_rx_cnt == r_rx_div - 16'd1) begin
                    w_rx_cnt_nxt   = 16'd0;
                    w_rx_par_nxt   = r_rxd_sync;
                    w_rx_state_nxt = ST_STOP;
                end else begin
                    w_rx_state_nxt = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (r_rx_cnt == r_rx_div - 16'd1) begin
                    w_rx_cnt_nxt   = 16'd0;
                    w_rx_state_nxt = ST_IDLE;
                    if (!r_rxd_sync) begin
                        w_ferr_set = 1'b1;
                    end else if (PARITY_EN && (r_rx_par != even_parity(r_rx_shift))) begin
                        w_perr_set = 1'b1;
                    end else begin
                        w_rx_push = 1'b1;
                    end
                end else begin
                    w_rx_state_nxt = ST_STOP;
                end
            end
            default: begin
                w_rx_state_nxt = ST_IDLE;
                w_rx_cnt_nxt   = 16'd0;
            end
        endcase
    end

    // TX state register; line output is registered and forced high by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= 16'd0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'd0;
            r_tx_div   <= DIV_MIN;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_div   <= w_tx_div_nxt;
            r_txd      <= w_txd_nxt;
        end
    end

    // TX next-state: each bit lasts r_tx_div cycles; STOP chains straight into next START
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt + 16'd1;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_div_nxt   = r_tx_div;
        w_txd_nxt      = r_txd;
        w_tx_pop       = 1'b0;
        case (r_tx_state)
            ST_IDLE: begin
                w_tx_cnt_nxt = 16'd0;
                if (!w_tx_empty) begin
                    w_tx_pop       = 1'b1;
                    w_tx_state_nxt = ST_START;
                    w_tx_shift_nxt = w_tx_load;
                    w_tx_div_nxt   = w_div_eff;
                    w_txd_nxt      = 1'b0;
                end else begin
                    w_tx_state_nxt = ST_IDLE;
                    w_txd_nxt      = 1'b1;
                end
            end
            ST_START: begin
                if (r_tx_cnt == r_tx_div - 16'd1) begin
                    w_tx_cnt_nxt   = 16'd0;
                    w_tx_state_nxt = ST_DATA;
                    w_tx_bit_nxt   = 3'd0;
                    w_txd_nxt      = r_tx_shift[0];
                end else begin
                    w_tx_state_nxt = ST_START;
                end
            end
            ST_DATA: begin
                if (r_tx_cnt == r_tx_div - 16'd1) begin
                    w_tx_cnt_nxt = 16'd0;
                    if (r_tx_bit == LAST_BIT) begin
                        if (PARITY_EN) begin
                            w_tx_state_nxt = ST_PARITY;
                            w_txd_nxt      = even_parity(r_tx_shift);
                        end else begin
                            w_tx_state_nxt = ST_STOP;
                            w_txd_nxt      = 1'b1;
                        end
                    end else begin
                        w_tx_bit_nxt = r_tx_bit + 3'd1;
                        w_txd_nxt    = r_tx_shift[r_tx_bit + 3'd1];
                    end
                end else begin
                    w_tx_state_nxt = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (r_tx_cnt == r_tx_div - 16'd1) begin
                    w_tx_cnt_nxt   = 16'd0;
                    w_tx_state_nxt = ST_STOP;
                    w_txd_nxt      = 1'b1;
                end else begin
                    w_tx_state_nxt = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (r_tx_cnt == r_tx_div - 16'd1) begin
                    w_tx_cnt_nxt = 16'd0;
                    if (!w_tx_empty) begin
                        w_tx_pop       = 1'b1;
                        w_tx_state_nxt = ST_START;
                        w_tx_shift_nxt = w_tx_load;
                        w_tx_div_nxt   = w_div_eff;
                        w_txd_nxt      = 1'b0;
                    end else begin
                        w_tx_state_nxt = ST_IDLE;
                        w_txd_nxt      = 1'b1;
                    end
                end else begin
                    w_tx_state_nxt = ST_STOP;
                end
            end
            default: begin
                w_tx_state_nxt = ST_IDLE;
                w_tx_cnt_nxt   = 16'd0;
                w_txd_nxt      = 1'b1;
            end
        endcase
    end

    assign uart_txd = r_txd;
    assign irq = (r_rx_ie & (w_rx_count != {CW{1'b0}})) |
                 (r_tx_empty_ie & (w_tx_count == {CW{1'b0}}) & (r_tx_state == ST_IDLE));

endmodule

// File: tb/tb_avs_uart_fifo.sv
// Self-checking bench for avs_uart_fifo: RX scoreboard queue, TX bit queue.
module tb_avs_uart_fifo;

    logic clk      = 1'b0;
    logic reset_n  = 1'b0;
    logic uart_rxd = 1'b1;
    logic irq;
    logic uart_txd;

    avs_uart_fifo_if avs ();

    avs_uart_fifo dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .avs      (avs),
        .irq      (irq),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] rx_exp_q [$];
    logic        tx_bit_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        avs.avs_address   = addr;
        avs.avs_writedata = data;
        avs.avs_write     = 1'b1;
        @(negedge clk);
        avs.avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        @(negedge clk);
        avs.avs_address = addr;
        avs.avs_read    = 1'b1;
        #1 data = avs.avs_readdata;
        @(negedge clk);
        avs.avs_read    = 1'b0;
    endtask

    // Drive one serial frame on rxd; frames expected to be accepted go to the scoreboard
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input logic par_flip, input int div, input logic accept);
        if (accept) rx_exp_q.push_back({23'd0, 1'b1, data});
        uart_rxd = 1'b0;
        tick(div);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = data[i];
            tick(div);
        end
`ifdef UART_PARITY_EN
        uart_rxd = (^data) ^ par_flip;
        tick(div);
`else
        if (par_flip) uart_rxd = 1'b1;
`endif
        uart_rxd = stop_bit;
        tick(div);
        uart_rxd = 1'b1;
        tick(div);
    endtask

    // Read RXDATA and compare with the oldest scoreboard entry
    task automatic rx_read_check(input string tag);
        logic [31:0] rd;
        bus_read(2'd0, rd);
        if (rx_exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            check_eq(tag, rd, rx_exp_q.pop_front());
        end
    endtask

    // Queue the expected line levels of a whole TX frame
    task automatic tx_expect(input logic [7:0] data);
        tx_bit_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_bit_q.push_back(data[i]);
`ifdef UART_PARITY_EN
        tx_bit_q.push_back(^data);
`endif
        tx_bit_q.push_back(1'b1);
    endtask

    // Wait for a start bit, then check every cycle of each queued bit
    task automatic tx_monitor(input int div);
        int budget;
        logic [31:0] seen;
        logic [31:0] mask;
        logic b;
        budget = 0;
        mask = (32'd1 << div) - 32'd1;
        @(negedge clk);
        while (uart_txd === 1'b1 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 200) begin
            check_eq("tx_start_timeout", 32'd0, 32'd1);
            tx_bit_q.delete();
        end else begin
            while (tx_bit_q.size() > 0) begin
                b = tx_bit_q.pop_front();
                seen = 32'd0;
                for (int s = 0; s < div; s++) begin
                    seen[s] = uart_txd;
                    @(negedge clk);
                end
                check_eq("tx_bit", seen, b ? mask : 32'd0);
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        int run;
        int budget;
        avs.avs_address   = 2'd0;
        avs.avs_read      = 1'b0;
        avs.avs_write     = 1'b0;
        avs.avs_writedata = 32'd0;

        // Reset state
        tick(3);
        check_eq("rst_txd", {31'd0, uart_txd}, 32'd1);
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(2'd2, rd); check_eq("rst_status", rd, 32'd0);
        bus_read(2'd3, rd); check_eq("rst_ctrl", rd, 32'd434);
        bus_read(2'd0, rd); check_eq("rst_rxdata", rd, 32'd0);

        // TX 0x55 at div 8
        bus_write(2'd3, 32'd8);
        bus_read(2'd3, rd); check_eq("ctrl_div8", rd, 32'd8);
        tx_expect(8'h55);
        bus_write(2'd1, 32'h55);
        tx_monitor(8);
        check_eq("tx_idle_high", {31'd0, uart_txd}, 32'd1);

        // RX 0xA3
        send_frame(8'hA3, 1'b1, 1'b0, 8, 1'b1);
        bus_read(2'd2, rd); check_eq("rx_count1", rd, 32'h0100_0000);
        rx_read_check("rx_a3");
        bus_read(2'd0, rd); check_eq("rx_empty_read", rd, 32'h0000_00A3);

        // Start glitch of 2 cycles
        uart_rxd = 1'b0;
        tick(2);
        uart_rxd = 1'b1;
        tick(20);
        bus_read(2'd2, rd); check_eq("glitch_status", rd, 32'd0);

        // Framing error
        send_frame(8'h5A, 1'b0, 1'b0, 8, 1'b0);
        tick(8);
        bus_read(2'd2, rd); check_eq("ferr_set", rd, 32'h0000_0004);
        bus_write(2'd2, 32'h4);
        bus_read(2'd2, rd); check_eq("ferr_clr", rd, 32'd0);

        // RX overflow: 17 frames into a 16-deep FIFO
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(8'h30 + i), 1'b1, 1'b0, 8, (i < 16));
        end
        bus_read(2'd2, rd); check_eq("ovf_status", rd, 32'h1000_0002);
        for (int i = 0; i < 16; i++) rx_read_check("ovf_data");
        bus_write(2'd2, 32'hF);
        bus_read(2'd2, rd); check_eq("ovf_clr", rd, 32'd0);

`ifdef UART_PARITY_EN
        // Bad parity on 0x07
        send_frame(8'h07, 1'b1, 1'b1, 8, 1'b0);
        bus_read(2'd2, rd); check_eq("perr_set", rd, 32'h0000_0008);
        bus_write(2'd2, 32'h8);
        bus_read(2'd2, rd); check_eq("perr_clr", rd, 32'd0);
`endif

        // RX interrupt
        bus_write(2'd3, 32'h0001_0008);
        check_eq("irq_rx_idle", {31'd0, irq}, 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0, 8, 1'b1);
        check_eq("irq_rx_set", {31'd0, irq}, 32'd1);
        rx_read_check("irq_data");
        check_eq("irq_rx_clr", {31'd0, irq}, 32'd0);
        bus_write(2'd3, 32'h0002_0008);
        check_eq("irq_tx_empty", {31'd0, irq}, 32'd1);

        // Divisor below minimum is clamped to 4
        bus_write(2'd3, 32'd2);
        bus_read(2'd3, rd); check_eq("ctrl_div2", rd, 32'd2);
        bus_write(2'd1, 32'hFF);
        budget = 0;
        @(negedge clk);
        while (uart_txd === 1'b1 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        run = 0;
        while (uart_txd === 1'b0 && run < 100) begin
            @(negedge clk);
            run++;
        end
        check_eq("div_clamp_start", run, 32'd4);
        tick(60);

        // Reset mid-frame returns the line high immediately
        bus_write(2'd3, 32'd8);
        bus_write(2'd1, 32'h00);
        budget = 0;
        @(negedge clk);
        while (uart_txd === 1'b1 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        tick(12);
        check_eq("mid_frame_low", {31'd0, uart_txd}, 32'd0);
        #2 reset_n = 1'b0;
        #1 check_eq("rst_mid_txd", {31'd0, uart_txd}, 32'd1);
        tick(2);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(2'd3, rd); check_eq("rst_mid_ctrl", rd, 32'd434);
        bus_read(2'd2, rd); check_eq("rst_mid_status", rd, 32'd0);
        check_eq("sb_drained", rx_exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
